// File: rtl/ir_pkg.sv
// ir_pkg: shared instruction field positions, NOP word and decoded-field struct
package ir_pkg;
    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int SH_HI = 10, SH_LO = 6;
    localparam int FN_HI = 5,  FN_LO = 0;
    localparam int I16_HI = 15, I16_LO = 0;
    localparam int I26_HI = 25, I26_LO = 0;
    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] imm26;
    } ir_fields_t;
endpackage

// File: rtl/ir_field_decode.sv
// ir_field_decode: splits an instruction word into MIPS fields and extends Imm16
module ir_field_decode
    import ir_pkg::*;
(
    input  logic [31:0] word,
    input  logic        ext_sel,
    output ir_fields_t  fields,
    output logic [31:0] imm_ext
);
    always_comb begin
        fields.op    = word[OP_HI:OP_LO];
        fields.rs    = word[RS_HI:RS_LO];
        fields.rt    = word[RT_HI:RT_LO];
        fields.rd    = word[RD_HI:RD_LO];
        fields.shamt = word[SH_HI:SH_LO];
        fields.funct = word[FN_HI:FN_LO];
        fields.imm16 = word[I16_HI:I16_LO];
        fields.imm26 = word[I26_HI:I26_LO];
        imm_ext      = {{16{ext_sel & word[I16_HI]}}, word[I16_HI:I16_LO]};
    end
endmodule

// File: rtl/ir_queue.sv
// ir_queue: circular instruction-register queue with PC tags, flush and head decode
module ir_queue
    import ir_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [31:0]                in_instr,
    input  logic [PCW-1:0]             in_pc,
    output logic                       in_ready,
    input  logic                       pop,
    input  logic                       ext_sel,
    output logic                       out_valid,
    output logic [31:0]                oIR,
    output logic [PCW-1:0]             oPC,
    output logic [5:0]                 Op,
    output logic [5:0]                 Funct,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [15:0]                Imm16,
    output logic [25:0]                Imm26,
    output logic [31:0]                imm_ext,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]    mem_ir [DEPTH];
    logic [PCW-1:0] mem_pc [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;
    ir_fields_t     f;

    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign do_push   = push & in_ready;
    assign do_pop    = pop & out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ir[i] <= NOP_WORD;
                mem_pc[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_ir[wr_ptr] <= in_instr;
                mem_pc[wr_ptr] <= in_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // an empty queue presents a NOP so the controller never decodes a stale word
    assign oIR = out_valid ? mem_ir[rd_ptr] : NOP_WORD;
    assign oPC = out_valid ? mem_pc[rd_ptr] : '0;

    ir_field_decode u_dec (
        .word    (oIR),
        .ext_sel (ext_sel),
        .fields  (f),
        .imm_ext (imm_ext)
    );

    assign Op    = f.op;
    assign rs    = f.rs;
    assign rt    = f.rt;
    assign rd    = f.rd;
    assign shamt = f.shamt;
    assign Funct = f.funct;
    assign Imm16 = f.imm16;
    assign Imm26 = f.imm26;
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed and random checks of ir_queue against a queue-based model
module tb_ir_queue;
    localparam int DEPTH = 4;
    localparam int PCW   = 32;

    logic clk = 0, rst_n = 0, flush = 0, push = 0, pop = 0, ext_sel = 0;
    logic [31:0] in_instr = 0;
    logic [PCW-1:0] in_pc = 0;
    logic in_ready, out_valid;
    logic [31:0] oIR, imm_ext;
    logic [PCW-1:0] oPC;
    logic [5:0] Op, Funct;
    logic [4:0] rs, rt, rd, shamt;
    logic [15:0] Imm16;
    logic [25:0] Imm26;
    logic [2:0] count;

    int checks = 0, errors = 0;
    logic [31:0]    mq [$];
    logic [PCW-1:0] pq [$];

    ir_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .in_instr(in_instr),
        .in_pc(in_pc), .in_ready(in_ready), .pop(pop), .ext_sel(ext_sel),
        .out_valid(out_valid), .oIR(oIR), .oPC(oPC), .Op(Op), .Funct(Funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .Imm16(Imm16), .Imm26(Imm26),
        .imm_ext(imm_ext), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] hw, hp, ie;
        hw = mq.size() > 0 ? mq[0] : 32'h0;
        hp = pq.size() > 0 ? pq[0] : 32'h0;
        ie = ext_sel ? 32'($signed(hw[15:0])) : 32'(hw[15:0]);
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), 32'(mq.size()));
        chk("oIR", oIR, hw);
        chk("oPC", oPC, hp);
        chk("Op", 32'(Op), 32'(hw >> 26));
        chk("rs", 32'(rs), (hw >> 21) & 32'h1f);
        chk("rt", 32'(rt), (hw >> 16) & 32'h1f);
        chk("rd", 32'(rd), (hw >> 11) & 32'h1f);
        chk("shamt", 32'(shamt), (hw >> 6) & 32'h1f);
        chk("Funct", 32'(Funct), hw & 32'h3f);
        chk("Imm16", 32'(Imm16), hw & 32'hffff);
        chk("Imm26", 32'(Imm26), hw & 32'h3ffffff);
        chk("imm_ext", imm_ext, ie);
    endtask

    task automatic step(input logic p, input logic po, input logic fl, input logic es,
                        input logic [31:0] w, input logic [31:0] pcv);
        bit acc, ep;
        push = p; pop = po; flush = fl; ext_sel = es; in_instr = w; in_pc = pcv;
        acc = p && !fl && mq.size() < DEPTH;
        ep  = po && !fl && mq.size() > 0;
        @(posedge clk);
        if (fl) begin
            mq.delete(); pq.delete();
        end else begin
            if (ep) begin void'(mq.pop_front()); void'(pq.pop_front()); end
            if (acc) begin mq.push_back(w); pq.push_back(pcv); end
        end
        #1 check_all();
    endtask

    logic [31:0] words [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

    initial begin
        #12 check_all();
        rst_n = 1;
        // lw $3,4($2)
        step(1, 0, 0, 0, 32'h8C430004, 32'h0);
        chk("lw_op", 32'(Op), 32'h23);
        chk("lw_rs", 32'(rs), 32'd2);
        chk("lw_rt", 32'(rt), 32'd3);
        chk("lw_imm", imm_ext, 32'h4);
        chk("lw_cnt", 32'(count), 32'd1);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h2022FFFF, 32'h4);
        chk("sext", imm_ext, 32'hFFFFFFFF);
        ext_sel = 0;
        #1 chk("zext", imm_ext, 32'h0000FFFF);
        check_all();
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, words[i], 32'(i * 4));
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_cnt", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("order", oIR, words[i]);
            step(0, 1, 0, 0, 0, 0);
        end
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ir", oIR, 32'd0);
        step(1, 0, 0, 0, 32'hA0000001, 32'h100);
        step(1, 0, 0, 0, 32'hA0000002, 32'h104);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, i[0], 32'hB0000000 + 32'(i), 32'h200 + 32'(i * 4));
            chk("steady_cnt", 32'(count), 32'd2);
        end
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'hC0000000 + 32'(i), 32'(i));
        step(1, 1, 1, 0, 32'hDEADBEEF, 32'h999);
        chk("flush_cnt", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_absent", oIR, 32'd0);
        step(1, 0, 0, 0, 32'h12345678, 32'h40);
        chk("post_flush_push", oIR, 32'h12345678);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 4), 1'($urandom), $urandom, $urandom);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'hE0000000 + 32'(i), 32'(i));
        #2 rst_n = 0;
        mq.delete(); pq.delete();
        #1 chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ir", oIR, 32'd0);
        check_all();
        #2 rst_n = 1;
        step(1, 0, 0, 0, 32'h0BADF00D, 32'h80);
        chk("post_rst_push", oIR, 32'h0BADF00D);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction-register queue for the multicycle MIPS datapath; the successor to the single-entry instruction register. It buffers up to DEPTH fetched instruction words, each tagged with its fetch PC, between instruction memory and the controller. It presents the oldest entry's decoded fields every cycle, adds an extended-immediate output, and supports flush on branch or jump redirect.

## Interface
- DEPTH, 4: number of entries; power of two, 2..16
- PCW, 32: width of the PC tag stored with each word
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (redirect)
- push  in  1  write in_instr/in_pc; accepted only when in_ready=1
- in_instr  in  32  instruction word from instruction memory
- in_pc  in  PCW  PC of in_instr
- in_ready  out  1  queue not full
- pop  in  1  consume head entry (controller's IRWr-equivalent advance); ignored when out_valid=0
- ext_sel  in  1  0: zero-extend Imm16, 1: sign-extend Imm16
- out_valid  out  1  head entry present
- oIR  out  32  head instruction word
- oPC  out  PCW  head PC tag
- Op, Funct  out  6  oIR[31:26], oIR[5:0]
- rs, rt, rd, shamt  out  5  oIR[25:21], [20:16], [15:11], [10:6]
- Imm16  out  16  oIR[15:0]
- Imm26  out  26  oIR[25:0]
- imm_ext  out  32  Imm16 extended per ext_sel
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a registered count.
- Accepted push: write array[wr_ptr], wr_ptr+1, count+1.
- Effective pop (pop & out_valid): rd_ptr+1, count-1.
- Push and effective pop in the same cycle: both pointers advance and count is unchanged. When full, in_ready=0, so the push is dropped even if pop is high in that cycle; in_ready has no combinational path from pop.
- flush has priority over push and pop. Pointers and count go to 0 and the same-cycle push is discarded.
- Head outputs are a combinational read of array[rd_ptr]. When out_valid=0, oIR, oPC and all fields are forced to 0 (NOP), so the controller never sees stale words.
- imm_ext: ext_sel=1 gives {{16{Imm16[15]}},Imm16}; ext_sel=0 gives {16'b0,Imm16}.
- Reset (async, rst_n low): pointers=0, count=0, array cleared to 0. Outputs: out_valid=0, in_ready=1, oIR=0, oPC=0, all fields 0, imm_ext=0. Reset asserted mid-operation takes effect immediately, regardless of clk.

## Timing
- Push at edge N: the entry is visible on the head outputs after edge N (if the queue was empty), with out_valid=1 during cycle N+1. No bypass from in_instr to oIR.
- Pop at edge N: the next entry appears after edge N.
- Flush at edge N: out_valid=0 and count=0 after edge N. A push in cycle N+1 is accepted normally.
- in_ready = (count != DEPTH), decoded from registered state.
- count, in_ready and out_valid all change only on clk edges or on reset.

## Structure
- Shared package ir_pkg holds:
  - field position constants (OP_HI/LO, RS_HI/LO, …)
  - NOP_WORD = 32'h0
  - an ir_fields_t struct (op, rs, rt, rd, shamt, funct, imm16, imm26)
- One combinational sub-module, ir_field_decode: word + ext_sel in, ir_fields_t + imm_ext out. The same sub-module is reused by the pipeline variant.
- Storage, pointers and control live in ir_queue.

## Test plan
- Reset, then push 0x8C430004 at PC 0x0 → after one edge: out_valid=1, Op=0x23, rs=2, rt=3, Imm16=0x0004, imm_ext=0x00000004, count=1.
- Push 0x2022FFFF with ext_sel=1 → imm_ext=0xFFFFFFFF. With ext_sel=0 → imm_ext=0x0000FFFF.
- DEPTH=4: push 5 distinct words without pop → 5th dropped, in_ready=0, count=4. Four pops return words 1–4 in order, then out_valid=0 and oIR=0.
- Steady state: push and pop every cycle for 20 cycles with count=2 → count stays 2 and order is preserved across pointer wrap.
- Load 3 entries, then assert flush together with push and pop → count=0, out_valid=0, and the pushed word is absent on the following cycles.
- Assert rst_n low mid-stream between clock edges → outputs go to 0 and in_ready=1 immediately. After release, a push is accepted on the first edge.
